request_arbiter: RTL
====================

REQUEST_ARBITER -- requirements
Module: request_arbiter

Interface
REQ-001 SHALL have parameter NPORTS, default 2, meaning number of requester ports; port 0 is data, port 1 is instruction.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-003 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-004 SHALL have parameter ARB_MODE, default 0, meaning 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of ACCESS cycles before an abort; the legal range is 1..255.
REQ-006 SHALL have one clock and an asynchronous active-low reset, with the ports listed below.
REQ-007 clk  input  1  system clock, rising edge.
REQ-008 nRST  input  1  asynchronous active-low reset.
REQ-009 req  input  NPORTS  per-port request, held high until that port's ready pulse.
REQ-010 wen  input  NPORTS  per-port write enable: 1 = store, 0 = load.
REQ-011 addr  input  NPORTS*ADDR_W  packed per-port addresses; port i occupies slice i.
REQ-012 wdata  input  NPORTS*DATA_W  packed per-port store data.
REQ-013 ready  output  NPORTS  one-cycle completion pulse per port.
REQ-014 err  output  NPORTS  asserted alongside ready when the access timed out.
REQ-015 rdata  output  NPORTS*DATA_W  per-port registered load data.
REQ-016 ram_ren  output  1  RAM read strobe.
REQ-017 ram_wen  output  1  RAM write strobe.
REQ-018 ram_addr  output  ADDR_W  RAM address.
REQ-019 ram_store  output  DATA_W  RAM write data.
REQ-020 ram_load  input  DATA_W  RAM read data, valid when ram_ready is high.
REQ-021 ram_ready  input  1  RAM completion, single cycle.
REQ-022 busy  output  1  high in every state other than IDLE.

Function
REQ-023 SHALL implement the FSM states IDLE, ACCESS and DONE.
REQ-024 IDLE: if any req bit is set, SHALL select a winner per ARB_MODE, latch the winner's index, addr, wen and wdata, clear the timeout counter, and go to ACCESS; otherwise SHALL stay in IDLE.
REQ-025 ACCESS: SHALL drive ram_addr and ram_store from the latched values, with ram_ren = ~wen_latched and ram_wen = wen_latched; all four outputs SHALL be registered and stable for the whole state.
REQ-026 ACCESS with ram_ready high: SHALL capture ram_load into rdata[winner] for loads only, and go to DONE with err_next = 0.
REQ-027 ACCESS with ram_ready low: SHALL increment the counter; when the counter reaches TIMEOUT it SHALL go to DONE with err_next = 1, and rdata SHALL be unchanged.
REQ-028 DONE: SHALL pulse ready[winner], and err[winner] if set, for exactly one cycle; ram_ren and ram_wen SHALL be 0; SHALL return to IDLE.
REQ-029 Minimum latency: a req sampled in cycle 0 with ram_ready high in cycle 1 SHALL produce ready in cycle 2.
REQ-030 SHALL have at most one access outstanding; losing ports wait with req held and SHALL get no ready pulse.
REQ-031 In round-robin mode, the pointer SHALL advance to winner+1 (mod NPORTS) on every DONE, including timeouts; the search order SHALL start at the pointer.
REQ-032 In fixed-priority mode, the lowest-indexed active req SHALL win; starvation of higher indices is permitted.
REQ-033 Deasserting req during ACCESS SHALL NOT abort the access; the ready pulse SHALL still issue.
REQ-034 A ram_ready seen in IDLE or DONE SHALL be ignored.
REQ-035 The IDLE-to-IDLE turnaround after DONE SHALL be one cycle: a held req is re-arbitrated in the IDLE cycle that follows DONE.
REQ-036 rdata[i] SHALL hold its value until the next successful load by port i.

Reset
REQ-037 While nRST is low, the block SHALL be in IDLE with ready, err, ram_ren, ram_wen and busy = 0, ram_addr = 0, ram_store = 0, all rdata = 0, and the round-robin pointer = 0.
REQ-038 Reset during ACCESS or DONE SHALL abandon the access immediately, with no ready pulse after release.

Structure
REQ-039 A shared package request_pkg SHALL hold the state enum (IDLE, ACCESS, DONE) and the ARB_MODE constants ARB_FIXED = 0 and ARB_RR = 1.
REQ-040 There SHALL be one sub-module, rr_arbiter (NPORTS, ARB_MODE), which is combinational from req and pointer to a one-hot grant plus an index.

Verification
REQ-041 Port 1 loads addr 0x40 and the RAM returns 0xDEADBEEF with ram_ready in the first ACCESS cycle -> ready[1] in cycle 2, rdata[1] = 0xDEADBEEF, ram_ren high for exactly 1 cycle.
REQ-042 Ports 0 and 1 request simultaneously with ARB_MODE = 0 -> port 0 is served first and port 1 second; ready pulses are 3 cycles apart when the RAM has zero wait.
REQ-043 With ARB_MODE = 1, both ports request continuously for 6 accesses -> the grant order is 0, 1, 0, 1, 0, 1.
REQ-044 Port 0 stores 0x12345678 to 0x80 and ram_ready never arrives, TIMEOUT = 15 -> ready[0] and err[0] pulse after 15 ACCESS cycles, and rdata[0] is unchanged.
REQ-045 nRST is asserted in the 2nd ACCESS cycle of a port 1 load -> all outputs are 0 immediately, and no ready[1] appears after release.
REQ-046 req[1] drops in ACCESS while the RAM takes 3 wait cycles -> ready[1] still pulses once, and the next access begins one cycle after DONE.

Source files
------------

// File: rtl/request_pkg.sv
// Shared state encoding, arbitration-mode constants and a width helper
// for the request arbiter and its grant logic.
package request_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Port-index width; kept at one bit minimum so a single-port build stays legal.
  function automatic int idx_width(input int nports);
    return (nports > 1) ? $clog2(nports) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational grant selection: fixed priority (lowest index) or
// round-robin search starting at the pointer.
module rr_arbiter
  import request_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int IDX_W    = idx_width(NPORTS)
) (
  input  logic [NPORTS-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NPORTS-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through the loop infers a latch.
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = 0; k < NPORTS; k++) begin
      if (ARB_MODE == ARB_RR) cand = IDX_W'((int'(ptr_i) + k) % NPORTS);
      else                    cand = IDX_W'(k);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        grant_o[cand]  = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/request_arbiter.sv
// Multi-port arbiter funnelling single load/store requests onto one RAM
// port, with per-port completion pulses and an access timeout.
module request_arbiter
  import request_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int TIMEOUT  = 15
) (
  input  logic                     clk,
  input  logic                     nRST,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        wen,
  input  logic [NPORTS*ADDR_W-1:0] addr,
  input  logic [NPORTS*DATA_W-1:0] wdata,
  output logic [NPORTS-1:0]        ready,
  output logic [NPORTS-1:0]        err,
  output logic [NPORTS*DATA_W-1:0] rdata,
  output logic                     ram_ren,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_store,
  input  logic [DATA_W-1:0]        ram_load,
  input  logic                     ram_ready,
  output logic                     busy
);

  localparam int         IDX_W     = idx_width(NPORTS);
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("request_arbiter: TIMEOUT must be in 1..255");
  end

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         win_q, win_d, ptr_q, ptr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     ram_ren_q, ram_ren_d, ram_wen_q, ram_wen_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_store_q, ram_store_d;
  logic [NPORTS-1:0]        ready_q, ready_d, err_q, err_d;
  logic [NPORTS*DATA_W-1:0] rdata_q, rdata_d;

  logic [NPORTS-1:0]        grant;
  logic [IDX_W-1:0]         grant_idx;
  logic                     grant_valid;

  rr_arbiter #(
    .NPORTS  (NPORTS),
    .ARB_MODE(ARB_MODE),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (grant_idx),
    .valid_o(grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ram_ren_d   = 1'b0;
    ram_wen_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_store_d = ram_store_q;
    ready_d     = '0;
    err_d       = '0;
    rdata_d     = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          state_d     = ACCESS;
          win_d       = grant_idx;
          cnt_d       = '0;
          ram_addr_d  = addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          ram_store_d = wdata[int'(grant_idx)*DATA_W +: DATA_W];
          ram_wen_d   = |(wen & grant);
          ram_ren_d   = ~|(wen & grant);
        end
      end
      ACCESS: begin
        // Strobes stay registered and steady until the cycle we leave ACCESS.
        ram_ren_d = ram_ren_q;
        ram_wen_d = ram_wen_q;
        if (ram_ready) begin
          if (ram_ren_q) rdata_d[int'(win_q)*DATA_W +: DATA_W] = ram_load;
          state_d        = DONE;
          ready_d[win_q] = 1'b1;
          ram_ren_d      = 1'b0;
          ram_wen_d      = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_C) begin
            state_d        = DONE;
            ready_d[win_q] = 1'b1;
            err_d[win_q]   = 1'b1;
            ram_ren_d      = 1'b0;
            ram_wen_d      = 1'b0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (ARB_MODE == ARB_RR) ptr_d = (int'(win_q) == NPORTS-1) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      win_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
      ready_q     <= '0;
      err_q       <= '0;
      // NOTE: rdata is a small register bank rather than a RAM macro, so it is reset with everything else.
      rdata_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      win_q       <= win_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ram_ren_q   <= ram_ren_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_store_q <= ram_store_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
    end
  end

  assign ready     = ready_q;
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign ram_ren   = ram_ren_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_store = ram_store_q;
  assign busy      = (state_q != IDLE);

endmodule
